// File: rtl/branch_redirect_ctrl.sv
// Branch redirect / pipeline-hazard controller for the RV32I core.
// Sequences PC redirects with IF/ID and ID/EX flushes, holds a redirect
// while fetch is stalled, inserts load-use bubbles and keeps debug state.
module branch_redirect_ctrl #(
  parameter int PC_WIDTH  = 9,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid,
  input  logic                 ex_pcsel,
  input  logic [31:0]          ex_target,
  input  logic                 ex_memread,
  input  logic [4:0]           ex_rd,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 fetch_ready,
  output logic                 pc_write,
  output logic                 pc_sel,
  output logic [PC_WIDTH-1:0]  pc_target,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic [CNT_WIDTH-1:0] redirect_cnt,
  output logic                 misalign_err
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SHADOW = 2'd2;

  logic [1:0]          state, state_nxt;
  logic [PC_WIDTH-1:0] redirect_q, tgt;
  logic                redirect, load_use;
  logic                cnt_inc, latch_q, mis_set;
  logic                unused_tgt_hi;

  assign redirect = ex_valid & ex_pcsel;
  assign load_use = ex_valid & ex_memread & (ex_rd != 5'd0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  // Targets are forced word-aligned; the dropped low bits feed misalign_err.
  assign tgt = {ex_target[PC_WIDTH-1:2], 2'b00};
  // Upper target bits beyond the PC register width are intentionally dropped.
  assign unused_tgt_hi = ^ex_target[31:PC_WIDTH];

  // Output decode and next-state selection; reset forces a full flush.
  always_comb begin
    state_nxt  = state;
    pc_write   = 1'b0;
    pc_sel     = 1'b0;
    pc_target  = '0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    cnt_inc    = 1'b0;
    latch_q    = 1'b0;
    mis_set    = 1'b0;
    if (reset) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          if (redirect) begin
            // Redirect beats load-use: the stalled instruction is squashed anyway.
            pc_sel     = 1'b1;
            pc_target  = tgt;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            mis_set    = (ex_target[1:0] != 2'b00);
            if (fetch_ready) begin
              pc_write   = 1'b1;
              ifid_write = 1'b1;
              cnt_inc    = 1'b1;
              state_nxt  = S_SHADOW;
            end else begin
              latch_q   = 1'b1;
              state_nxt = S_WAIT;
            end
          end else if (load_use) begin
            idex_flush = 1'b1;
          end else begin
            pc_write   = fetch_ready;
            ifid_write = fetch_ready;
          end
        end
        S_WAIT: begin
          // Replay the held target until fetch accepts it; EX is ignored.
          pc_sel     = 1'b1;
          pc_target  = redirect_q;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          pc_write   = fetch_ready;
          ifid_write = fetch_ready;
          if (fetch_ready) begin
            cnt_inc   = 1'b1;
            state_nxt = S_SHADOW;
          end
        end
        S_SHADOW: begin
          // EX holds the bubble from the redirect flush; nothing to honour.
          pc_write   = fetch_ready;
          ifid_write = fetch_ready;
          state_nxt  = S_RUN;
        end
        default: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_nxt  = S_RUN;
        end
      endcase
    end
  end

  // State, held redirect target, redirect counter and sticky misalign flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_RUN;
      redirect_q   <= '0;
      redirect_cnt <= '0;
      misalign_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch_q) redirect_q <= tgt;
      if (cnt_inc) redirect_cnt <= redirect_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      if (mis_set) misalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomized bench for branch_redirect_ctrl against a transaction-level model
// (pending redirect flag, shadow-cycle flag, integer counter).
module tb_branch_redirect_ctrl;
  localparam int PW = 9;
  localparam int CW = 5;  // narrow counter so wrap-around is reachable quickly

  logic          clk = 1'b0;
  logic          reset, ex_valid, ex_pcsel, ex_memread, fetch_ready;
  logic [31:0]   ex_target;
  logic [4:0]    ex_rd, id_rs1, id_rs2;
  logic          pc_write, pc_sel, ifid_write, ifid_flush, idex_flush, misalign_err;
  logic [PW-1:0] pc_target;
  logic [CW-1:0] redirect_cnt;

  int tests = 0;
  int fails = 0;

  // model state
  bit          known = 0;
  bit          pend = 0, shadow = 0, mis = 0;
  int unsigned pend_tgt = 0, cnt = 0;

  branch_redirect_ctrl #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_pcsel(ex_pcsel),
    .ex_target(ex_target), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .fetch_ready(fetch_ready),
    .pc_write(pc_write), .pc_sel(pc_sel), .pc_target(pc_target),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .redirect_cnt(redirect_cnt), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance the model at the edge.
  task automatic step(input bit rst, input bit v, input bit psel, input logic [31:0] tg,
                      input bit mr, input logic [4:0] rd, input logic [4:0] r1,
                      input logic [4:0] r2, input bit fr);
    bit e_pw, e_ps, e_iw, e_ifl, e_idf, chk_sel, chk_tgt, chk_iw;
    int unsigned e_pt, tgt;
    bit redir, lu;
    @(negedge clk);
    reset = rst; ex_valid = v; ex_pcsel = psel; ex_target = tg; ex_memread = mr;
    ex_rd = rd; id_rs1 = r1; id_rs2 = r2; fetch_ready = fr;
    #1;
    tgt   = tg & ((32'd1 << PW) - 32'd4);
    redir = v && psel;
    lu    = v && mr && rd != 0 && (rd == r1 || rd == r2);
    e_pw = 0; e_ps = 0; e_pt = 0; e_iw = 0; e_ifl = 0; e_idf = 0;
    chk_sel = 1; chk_tgt = 0; chk_iw = 1;
    if (rst) begin
      e_ifl = 1; e_idf = 1;
    end else if (pend) begin
      e_ps = 1; e_pt = pend_tgt; chk_tgt = 1; e_ifl = 1; e_idf = 1; e_pw = fr; chk_iw = 0;
    end else if (!shadow && redir) begin
      e_ifl = 1; e_idf = 1; e_pw = fr;
      if (fr) begin e_ps = 1; e_pt = tgt; chk_tgt = 1; e_iw = 1; end
      else begin chk_sel = 0; chk_iw = 0; end
    end else if (!shadow && lu) begin
      e_idf = 1; chk_sel = 0;
    end else begin
      e_pw = fr; e_iw = fr;
    end
    chk("pc_write", pc_write, e_pw);
    chk("ifid_flush", ifid_flush, e_ifl);
    chk("idex_flush", idex_flush, e_idf);
    if (chk_sel) chk("pc_sel", pc_sel, e_ps);
    if (chk_tgt) chk("pc_target", pc_target, e_pt);
    if (chk_iw)  chk("ifid_write", ifid_write, e_iw);
    if (known) begin
      chk("redirect_cnt", redirect_cnt, cnt % (1 << CW));
      chk("misalign_err", misalign_err, mis);
    end
    @(posedge clk);
    if (rst) begin
      known = 1; pend = 0; shadow = 0; mis = 0; cnt = 0;
    end else if (pend) begin
      if (fr) begin pend = 0; shadow = 1; cnt++; end
    end else if (shadow) begin
      shadow = 0;
    end else if (redir) begin
      if (tg[1:0] != 2'b00) mis = 1;
      if (fr) begin shadow = 1; cnt++; end
      else begin pend = 1; pend_tgt = tgt; end
    end
  endtask

  task automatic idle(input bit fr);
    step(0, 0, 0, 0, 0, 0, 0, 0, fr);
  endtask

  initial begin
    // 1: reset two cycles, then idle
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 32'h40, 0, 0, 0, 0, 1);
    idle(1);
    chk("rst_cnt", redirect_cnt, 0);
    // 2: zero-latency redirect, pcsel held through the shadow cycle
    step(0, 1, 1, 32'h40, 0, 0, 0, 0, 1);
    step(0, 1, 1, 32'h40, 0, 0, 0, 0, 1);
    idle(1);
    chk("cnt_after_redir", redirect_cnt, 1);
    // 3: redirect held three cycles by fetch
    step(0, 1, 1, 32'h80, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h120, 0, 0, 0, 0, 0);
    chk("wait_cnt", redirect_cnt, 1);
    idle(1);
    idle(1);
    chk("cnt_after_wait", redirect_cnt, 2);
    // 4: load-use stall, then rd=0 (no stall)
    step(0, 1, 0, 0, 1, 5, 3, 5, 1);
    idle(1);
    step(0, 1, 0, 0, 1, 0, 0, 0, 1);
    // 5: load-use with redirect in same cycle
    step(0, 1, 1, 32'h100, 1, 7, 7, 0, 1);
    idle(1);
    // 6: misaligned target, sticky
    step(0, 1, 1, 32'h46, 0, 0, 0, 0, 1);
    for (int i = 0; i < 11; i++) idle(1);
    chk("mis_sticky", misalign_err, 1);
    // counter wrap: fresh reset, then 2^CW redirects
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < (1 << CW); i++) begin
      step(0, 1, 1, 32'h10, 0, 0, 0, 0, 1);
      idle(1);
    end
    chk("cnt_wrap", redirect_cnt, 0);
    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(15) != 0) t[1:0] = 2'b00;
      step($urandom_range(99) == 0, $urandom_range(3) != 0, $urandom_range(3) == 0, t,
           $urandom_range(1), 5'($urandom_range(3)), 5'($urandom_range(3)),
           5'($urandom_range(3)), $urandom_range(9) < 7);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Pipeline control FSM for the RV32I core.
- Takes the EX-stage branch decision (PCSel and PCBranch from the branch unit) and sequences the PC redirect plus the IF/ID and ID/EX flushes.
- Holds a pending redirect while instruction fetch is not ready.
- Inserts load-use stall bubbles.
- Keeps a taken-redirect counter and a sticky misaligned-target flag for debug.

Parameters:
PC_WIDTH, 9, width of the architectural PC register; the target is truncated to this width.
CNT_WIDTH, 16, width of the taken-redirect counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
ex_valid  input  1  EX stage holds a real (non-bubble) instruction
ex_pcsel  input  1  branch/jump taken (branch unit PCSel)
ex_target  input  32  redirect target (branch unit PCBranch)
ex_memread  input  1  EX instruction is a load
ex_rd  input  5  EX destination register
id_rs1  input  5  ID source register 1
id_rs2  input  5  ID source register 2
fetch_ready  input  1  instruction memory accepts a new PC this cycle
pc_write  output  1  PC register load enable
pc_sel  output  1  1: load pc_target; 0: load PC+4
pc_target  output  PC_WIDTH  redirect PC
ifid_write  output  1  IF/ID register enable
ifid_flush  output  1  zero IF/ID this cycle
idex_flush  output  1  insert bubble into ID/EX this cycle
redirect_cnt  output  CNT_WIDTH  count of completed redirects
misalign_err  output  1  sticky: a redirect target had target[1:0] != 0

Behaviour:
- All outputs are combinational from state, registers and inputs. State, redirect_q, redirect_cnt and misalign_err are registered on the rising edge of clk.
- While reset=1, all outputs are forced: pc_write=0, pc_sel=0, pc_target=0, ifid_write=0, ifid_flush=1, idex_flush=1.
- On reset: state=RUN, redirect_q=0, redirect_cnt=0, misalign_err=0. Reset mid-WAIT discards the pending redirect.
- redirect = ex_valid & ex_pcsel. It is honoured only in state RUN.
- load_use = ex_valid & ex_memread & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
- Target formation: tgt = {ex_target[PC_WIDTH-1:2], 2'b00}. If ex_target[1:0] != 0 at an accepted redirect, set misalign_err=1; it stays set until reset.

State RUN:
- redirect & fetch_ready: pc_write=1, pc_sel=1, pc_target=tgt, ifid_flush=1, idex_flush=1, ifid_write=1. redirect_cnt increments. Next state SHADOW.
- redirect & !fetch_ready: pc_write=0, ifid_flush=1, idex_flush=1. Latch redirect_q=tgt. Next state WAIT. redirect_cnt is not incremented yet.
- !redirect & load_use: pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0. Stay in RUN. A redirect always wins over load_use.
- Otherwise: pc_write=fetch_ready, pc_sel=0, ifid_write=fetch_ready, no flushes.

State WAIT:
- pc_sel=1, pc_target=redirect_q, ifid_flush=1, idex_flush=1. EX inputs are ignored.
- When fetch_ready=1: pc_write=1, redirect_cnt increments, next state SHADOW. Otherwise stay in WAIT with pc_write=0.

State SHADOW (exactly 1 cycle after a completed redirect):
- EX holds a bubble, so ex_pcsel and load_use are ignored.
- pc_write=fetch_ready, pc_sel=0, ifid_write=fetch_ready, no flushes.
- Next state RUN.

Counter and latency:
- redirect_cnt wraps from all-ones to 0.
- Redirect latency is 0 cycles from an accepted redirect with fetch_ready=1: the PC loads at the same edge.
- Back-to-back redirect requests are impossible by construction: the SHADOW cycle masks them.

Test Plan:
1. Reset held 2 cycles, then released with idle inputs -> during reset ifid_flush=idex_flush=1 and pc_write=0; after release pc_write=1, pc_sel=0, redirect_cnt=0, misalign_err=0.
2. RUN, ex_valid=1, ex_pcsel=1, ex_target=0x0000_0040, fetch_ready=1 -> same cycle pc_sel=1, pc_target=0x040, both flushes=1; next cycle SHADOW with ex_pcsel=1 held, which is ignored (pc_sel=0); redirect_cnt=1.
3. Redirect to 0x0000_0080 with fetch_ready=0 for 3 cycles, then 1 -> pc_write=0 for 3 cycles with pc_target=0x080 and flushes held; load on the 4th cycle; redirect_cnt increments only then.
4. ex_memread=1, ex_rd=5, id_rs2=5, no redirect -> exactly one cycle of pc_write=0, ifid_write=0, idex_flush=1; with ex_rd=0 -> no stall.
5. Load-use and redirect in the same cycle -> redirect taken, both flushes=1, pc_write=1, no stall.
6. ex_target=0x0000_0046 -> pc_target=0x044 and misalign_err=1, still 1 after 10 more cycles; preload redirect_cnt to 0xFFFF, then one redirect -> counter reads 0.
